egress_dest_router: RTL and testbench
=====================================

Name: egress_dest_router

Overview:
- Sits directly downstream of the packet dispatcher and consumes its AXI-Stream output plus its tdest.
- Latches tdest on the first beat of each packet and steers the whole packet to one of M_COUNT master ports.
- Silently discards packets whose tdest is not below M_COUNT.
- One registered output stage; per-port packet counters and a discard counter for host statistics.

Parameters:
- AXIS_DATA_WIDTH, 64, data width of all streams
- AXIS_KEEP_WIDTH, AXIS_DATA_WIDTH/8, tkeep width
- AXIS_DEST_WIDTH, 2, width of s_axis_tdest
- M_COUNT, 3, number of master ports (1..2**AXIS_DEST_WIDTH)
- STAT_WIDTH, 32, width of every statistics counter

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- s_axis_tdata  in  AXIS_DATA_WIDTH  input data
- s_axis_tkeep  in  AXIS_KEEP_WIDTH  input byte enables
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready
- s_axis_tlast  in  1  input end of packet
- s_axis_tdest  in  AXIS_DEST_WIDTH  destination; sampled on first beat only
- m_axis_tdata  out  M_COUNT*AXIS_DATA_WIDTH  per-port data (port i at slice i)
- m_axis_tkeep  out  M_COUNT*AXIS_KEEP_WIDTH  per-port byte enables
- m_axis_tvalid  out  M_COUNT  per-port valid
- m_axis_tready  in  M_COUNT  per-port ready
- m_axis_tlast  out  M_COUNT  per-port end of packet
- rst_counters  in  1  synchronous clear of all statistics counters
- pkt_count  out  M_COUNT*STAT_WIDTH  packets delivered per port
- discard_count  out  STAT_WIDTH  packets discarded

Behaviour:
- Reset values: all m_axis_tvalid=0, s_axis_tready=0 during rst, state=IDLE, all counters=0. Data, keep and last registers are cleared to 0.
- Output register: out_valid, out_data, out_keep, out_last, out_sel. m_axis_tvalid[i]=out_valid&&(out_sel==i). Data, keep and last are broadcast to every port slice. Latency is one cycle from input handshake to output valid.
- States are IDLE, FORWARD and DISCARD.
- IDLE: on an accepted beat, if tdest<M_COUNT then out_sel<=tdest and the beat is loaded. If !tlast, go to FORWARD.
- IDLE: on an accepted beat with tdest>=M_COUNT, the beat is dropped. If !tlast, go to DISCARD. If tlast, discard_count increments.
- FORWARD: beats are loaded to the output register with out_sel held and s_axis_tdest ignored. An accepted tlast beat returns the block to IDLE.
- DISCARD: s_axis_tready=1 and beats are dropped. An accepted tlast beat increments discard_count and returns the block to IDLE.
- Ready in IDLE and FORWARD: s_axis_tready = !out_valid || m_axis_tready[out_sel]. This gives full throughput, one beat per cycle, with no bubble. In IDLE, if the new packet targets a discard destination, ready still follows this rule.
- out_valid clears on an output handshake with no new load. It is set by a load. A simultaneous handshake and load keeps it at 1 with the new beat.
- Backpressure: while m_axis_tready[out_sel]=0 and out_valid=1, the output holds stable and s_axis_tready=0. Other ports are never asserted.
- pkt_count[i] increments on m_axis_tvalid[i]&&m_axis_tready[i]&&out_last.
- Counters saturate at all-ones. rst_counters has priority over a same-cycle increment, so the result is 0.
- tkeep is passed unmodified. A zero tkeep beat is still forwarded.
- Reset mid-packet: state returns to IDLE and the pending output beat is lost. The next accepted beat is treated as a first beat and its tdest is sampled.

Optional Feature:
- Macro: EGRESS_ROUTER_BYTE_COUNT_EN.
- Defined: adds output byte_count, M_COUNT*STAT_WIDTH. byte_count[i] adds popcount(out_keep) on every handshake of port i. It saturates and is cleared by rst and rst_counters.
- Undefined: the port and logic are absent. Packet and discard counters are unchanged.

Test Plan:
- 3-beat packet, tdest=1, all ready=1 -> beats appear on port 1 only, 1 cycle after input, back to back. pkt_count[1]=1, others 0.
- tdest=3 with M_COUNT=3, 4-beat packet -> no m_axis_tvalid asserted, s_axis_tready=1 throughout, discard_count=1. The next packet with tdest=0 is delivered on port 0.
- Packet to port 2, m_axis_tready[2]=0 for 5 cycles mid-packet -> output data stable, s_axis_tready=0 for those 5 cycles, no beat lost or duplicated. s_axis_tdest toggled mid-packet does not change the port.
- Back-to-back single-beat packets with tdest 0,1,2,0 and no gaps -> each delivered to the correct port in order. pkt_count={1,1,2} for ports 2,1,0 respectively.
- rst_counters pulsed in the same cycle as a port-0 tlast handshake -> pkt_count[0]=0. Preloading pkt_count near all-ones and sending further packets -> the counter holds at all-ones.
- With EGRESS_ROUTER_BYTE_COUNT_EN, 2-beat packet to port 0 with tkeep 8'hFF then 8'h0F -> byte_count[0]=12.

Source files
------------

// File: rtl/egress_dest_router.sv
// -----------------------------------------------------------------------------
// egress_dest_router
//
// Purpose:
//   Steers whole AXI-Stream packets from one slave port to one of M_COUNT
//   master ports. The destination is taken from s_axis_tdest on the first
//   beat of each packet and held for the rest of the packet. Packets whose
//   destination is not below M_COUNT are accepted and silently dropped.
//   One registered output stage gives one cycle of latency and full
//   throughput. Per-port packet counters and a discard counter are kept for
//   host statistics; all counters saturate at all-ones.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   s_axis_*          slave stream (tdata, tkeep, tvalid, tready, tlast, tdest)
//   m_axis_*          M_COUNT master streams, port i in slice i; data, keep
//                     and last are broadcast, only tvalid is per port
//   rst_counters      synchronous clear of every statistics counter
//   pkt_count         packets delivered per port, port i in slice i
//   discard_count     packets dropped for an out-of-range destination
//   byte_count        (EGRESS_ROUTER_BYTE_COUNT_EN only) bytes delivered per
//                     port, counted as popcount(tkeep) on each handshake
//
// Build options:
//   EGRESS_ROUTER_BYTE_COUNT_EN  define to add the byte_count port and logic.
// -----------------------------------------------------------------------------
module egress_dest_router #(
    parameter int AXIS_DATA_WIDTH = 64,
    parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8,
    parameter int AXIS_DEST_WIDTH = 2,
    parameter int M_COUNT         = 3,
    parameter int STAT_WIDTH      = 32
) (
    input  logic                               clk,
    input  logic                               rst,

    input  logic [AXIS_DATA_WIDTH-1:0]         s_axis_tdata,
    input  logic [AXIS_KEEP_WIDTH-1:0]         s_axis_tkeep,
    input  logic                               s_axis_tvalid,
    output logic                               s_axis_tready,
    input  logic                               s_axis_tlast,
    input  logic [AXIS_DEST_WIDTH-1:0]         s_axis_tdest,

    output logic [M_COUNT*AXIS_DATA_WIDTH-1:0] m_axis_tdata,
    output logic [M_COUNT*AXIS_KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic [M_COUNT-1:0]                 m_axis_tvalid,
    input  logic [M_COUNT-1:0]                 m_axis_tready,
    output logic [M_COUNT-1:0]                 m_axis_tlast,

    input  logic                               rst_counters,
    output logic [M_COUNT*STAT_WIDTH-1:0]      pkt_count,
    output logic [STAT_WIDTH-1:0]              discard_count
`ifdef EGRESS_ROUTER_BYTE_COUNT_EN
    ,
    output logic [M_COUNT*STAT_WIDTH-1:0]      byte_count
`endif
);

    // -------------------------------------------------------------------------
    // Types and helpers
    // -------------------------------------------------------------------------
    typedef enum logic [1:0] {
        IDLE    = 2'd0,  // waiting for the first beat of a packet
        FORWARD = 2'd1,  // passing the rest of a routed packet
        DISCARD = 2'd2   // swallowing the rest of an unroutable packet
    } state_e;

    // Saturating add: any carry out of the counter pins it at all-ones.
    function automatic logic [STAT_WIDTH-1:0] sat_add(
        input logic [STAT_WIDTH-1:0] cnt,
        input logic [STAT_WIDTH-1:0] amt
    );
        logic [STAT_WIDTH:0] sum;
        sum = {1'b0, cnt} + {1'b0, amt};
        return sum[STAT_WIDTH] ? {STAT_WIDTH{1'b1}} : sum[STAT_WIDTH-1:0];
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_e                       state_q,     state_d;
    logic                         out_valid_q, out_valid_d;
    logic [AXIS_DATA_WIDTH-1:0]   out_data_q,  out_data_d;
    logic [AXIS_KEEP_WIDTH-1:0]   out_keep_q,  out_keep_d;
    logic                         out_last_q,  out_last_d;
    logic [AXIS_DEST_WIDTH-1:0]   out_sel_q,   out_sel_d;

    logic [STAT_WIDTH-1:0]        pkt_count_q     [M_COUNT];
    logic [STAT_WIDTH-1:0]        pkt_count_d     [M_COUNT];
    logic [STAT_WIDTH-1:0]        discard_count_q, discard_count_d;

    // -------------------------------------------------------------------------
    // Decode of the output selector and the input handshake
    // -------------------------------------------------------------------------
    logic [M_COUNT-1:0] sel_onehot;
    logic               sel_ready;    // ready of the port the output register feeds
    logic               dest_ok;      // incoming tdest names an existing port
    logic               accept;       // input handshake this cycle
    logic               out_fire;     // output handshake this cycle
    logic               load;         // accepted beat goes into the output register
    logic               discard_done; // last beat of a dropped packet accepted

    always_comb begin
        // NOTE: every combinational output gets a default before any branch so
        // no path leaves it unassigned, which would otherwise infer a latch.
        sel_onehot = '0;
        for (int i = 0; i < M_COUNT; i++) begin
            if (int'(out_sel_q) == i) begin
                sel_onehot[i] = 1'b1;
            end
        end
        sel_ready = |(m_axis_tready & sel_onehot);
        dest_ok   = int'(s_axis_tdest) < M_COUNT;
        out_fire  = out_valid_q && sel_ready;
    end

    // Ready is held low in reset. While dropping, nothing is ever loaded so
    // the output register cannot block. Otherwise a beat is taken whenever the
    // output register is empty or draining this cycle; the first beat of a
    // doomed packet obeys the same rule because its fate is not yet known.
    always_comb begin
        s_axis_tready = 1'b0;
        if (!rst) begin
            if (state_q == DISCARD) begin
                s_axis_tready = 1'b1;
            end else begin
                s_axis_tready = !out_valid_q || sel_ready;
            end
        end
    end

    assign accept = s_axis_tvalid && s_axis_tready;

    // -------------------------------------------------------------------------
    // Next-state and output register
    // -------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_keep_d   = out_keep_q;
        out_last_d   = out_last_q;
        out_sel_d    = out_sel_q;
        load         = 1'b0;
        discard_done = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (dest_ok) begin
                        load      = 1'b1;
                        out_sel_d = s_axis_tdest;
                        if (!s_axis_tlast) begin
                            state_d = FORWARD;
                        end
                    end else if (s_axis_tlast) begin
                        discard_done = 1'b1;
                    end else begin
                        state_d = DISCARD;
                    end
                end
            end
            FORWARD: begin
                // out_sel is frozen here; s_axis_tdest is ignored mid-packet.
                if (accept) begin
                    load = 1'b1;
                    if (s_axis_tlast) begin
                        state_d = IDLE;
                    end
                end
            end
            DISCARD: begin
                if (accept && s_axis_tlast) begin
                    discard_done = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A drain empties the register unless a new beat replaces it in the
        // same cycle, which keeps valid high with no bubble.
        if (out_fire) begin
            out_valid_d = 1'b0;
        end
        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = s_axis_tdata;
            out_keep_d  = s_axis_tkeep;
            out_last_d  = s_axis_tlast;
        end
    end

    // -------------------------------------------------------------------------
    // Statistics next-state; rst_counters wins over a same-cycle increment
    // -------------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < M_COUNT; i++) begin
            if (rst_counters) begin
                pkt_count_d[i] = '0;
            end else if (out_valid_q && sel_onehot[i] && m_axis_tready[i] && out_last_q) begin
                pkt_count_d[i] = sat_add(pkt_count_q[i], STAT_WIDTH'(1));
            end else begin
                pkt_count_d[i] = pkt_count_q[i];
            end
        end

        if (rst_counters) begin
            discard_count_d = '0;
        end else if (discard_done) begin
            discard_count_d = sat_add(discard_count_q, STAT_WIDTH'(1));
        end else begin
            discard_count_d = discard_count_q;
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments only, so every flop
    // samples the values from before the edge regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            out_valid_q     <= 1'b0;
            out_data_q      <= '0;
            out_keep_q      <= '0;
            out_last_q      <= 1'b0;
            out_sel_q       <= '0;
            discard_count_q <= '0;
            // NOTE: the counter arrays are plain flops, not a RAM, so clearing
            // every entry in reset is legal and costs no extra memory ports.
            for (int i = 0; i < M_COUNT; i++) begin
                pkt_count_q[i] <= '0;
            end
        end else begin
            state_q         <= state_d;
            out_valid_q     <= out_valid_d;
            out_data_q      <= out_data_d;
            out_keep_q      <= out_keep_d;
            out_last_q      <= out_last_d;
            out_sel_q       <= out_sel_d;
            discard_count_q <= discard_count_d;
            for (int i = 0; i < M_COUNT; i++) begin
                pkt_count_q[i] <= pkt_count_d[i];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Optional per-port byte counters
    // -------------------------------------------------------------------------
`ifdef EGRESS_ROUTER_BYTE_COUNT_EN
    logic [STAT_WIDTH-1:0] keep_pop;
    logic [STAT_WIDTH-1:0] byte_count_q [M_COUNT];
    logic [STAT_WIDTH-1:0] byte_count_d [M_COUNT];

    always_comb begin
        keep_pop = '0;
        for (int b = 0; b < AXIS_KEEP_WIDTH; b++) begin
            keep_pop = keep_pop + STAT_WIDTH'(out_keep_q[b]);
        end
        for (int i = 0; i < M_COUNT; i++) begin
            if (rst_counters) begin
                byte_count_d[i] = '0;
            end else if (out_valid_q && sel_onehot[i] && m_axis_tready[i]) begin
                byte_count_d[i] = sat_add(byte_count_q[i], keep_pop);
            end else begin
                byte_count_d[i] = byte_count_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < M_COUNT; i++) begin
                byte_count_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < M_COUNT; i++) begin
                byte_count_q[i] <= byte_count_d[i];
            end
        end
    end

    always_comb begin
        byte_count = '0;
        for (int i = 0; i < M_COUNT; i++) begin
            byte_count[i*STAT_WIDTH +: STAT_WIDTH] = byte_count_q[i];
        end
    end
`else
    // Byte counting is compiled out; packet and discard counters are unaffected.
`endif

    // -------------------------------------------------------------------------
    // Outputs: payload broadcast to every port, valid only on the selected one
    // -------------------------------------------------------------------------
    assign m_axis_tdata  = {M_COUNT{out_data_q}};
    assign m_axis_tkeep  = {M_COUNT{out_keep_q}};
    assign m_axis_tlast  = {M_COUNT{out_last_q}};
    assign m_axis_tvalid = sel_onehot & {M_COUNT{out_valid_q}};
    assign discard_count = discard_count_q;

    always_comb begin
        pkt_count = '0;
        for (int i = 0; i < M_COUNT; i++) begin
            pkt_count[i*STAT_WIDTH +: STAT_WIDTH] = pkt_count_q[i];
        end
    end

endmodule

// File: tb/tb_egress_dest_router.sv
// -----------------------------------------------------------------------------
// tb_egress_dest_router
//
// Directed bench for egress_dest_router with M_COUNT=3 and 4-bit statistics
// counters so saturation is reachable in a few packets. Every accepted beat
// with a routable destination is pushed to that port's expected queue; a
// monitor pops and compares on each output handshake. Inputs change 1 ns
// after the rising edge, outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_egress_dest_router;

    localparam int DW    = 64;
    localparam int KW    = DW / 8;
    localparam int DESTW = 2;
    localparam int M     = 3;
    localparam int SW    = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic [DW-1:0]       s_axis_tdata;
    logic [KW-1:0]       s_axis_tkeep;
    logic                s_axis_tvalid;
    logic                s_axis_tready;
    logic                s_axis_tlast;
    logic [DESTW-1:0]    s_axis_tdest;
    logic [M*DW-1:0]     m_axis_tdata;
    logic [M*KW-1:0]     m_axis_tkeep;
    logic [M-1:0]        m_axis_tvalid;
    logic [M-1:0]        m_axis_tready;
    logic [M-1:0]        m_axis_tlast;
    logic                rst_counters;
    logic [M*SW-1:0]     pkt_count;
    logic [SW-1:0]       discard_count;
`ifdef EGRESS_ROUTER_BYTE_COUNT_EN
    logic [M*SW-1:0]     byte_count;
`endif

    always #5 clk = ~clk;

    egress_dest_router #(
        .AXIS_DATA_WIDTH (DW),
        .AXIS_KEEP_WIDTH (KW),
        .AXIS_DEST_WIDTH (DESTW),
        .M_COUNT         (M),
        .STAT_WIDTH      (SW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tdest  (s_axis_tdest),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .rst_counters  (rst_counters),
        .pkt_count     (pkt_count),
        .discard_count (discard_count)
`ifdef EGRESS_ROUTER_BYTE_COUNT_EN
        ,
        .byte_count    (byte_count)
`endif
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
    } beat_t;

    typedef struct packed {
        int c;
        int port;
    } lat_t;

    beat_t exp_q [M][$];
    lat_t  lat_q [$];

    int    checks   = 0;
    int    failures = 0;
    int    cyc      = 0;
    int    last_wait;
    int    pkt_dest = 0;
    logic  mon_en   = 1'b0;
    beat_t mon_e;
    lat_t  mon_l;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int pending();
        int n;
        n = lat_q.size();
        for (int i = 0; i < M; i++) n += exp_q[i].size();
        return n;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: scoreboard pops, one-cycle latency, one-hot valid.
    always @(negedge clk) begin
        if (mon_en) begin
            check("valid_onehot", 64'($countones(m_axis_tvalid) <= 1), 64'd1);
            while (lat_q.size() > 0 && lat_q[0].c < cyc) begin
                mon_l = lat_q.pop_front();
                check($sformatf("latency_p%0d", mon_l.port), 64'(m_axis_tvalid[mon_l.port]), 64'd1);
            end
            for (int i = 0; i < M; i++) begin
                if (m_axis_tvalid[i] && m_axis_tready[i]) begin
                    check($sformatf("beat_expected_p%0d", i), 64'(exp_q[i].size() != 0), 64'd1);
                    if (exp_q[i].size() != 0) begin
                        mon_e = exp_q[i].pop_front();
                        check($sformatf("data_p%0d", i), m_axis_tdata[i*DW +: DW], mon_e.data);
                        check($sformatf("keep_p%0d", i), 64'(m_axis_tkeep[i*KW +: KW]), 64'(mon_e.keep));
                        check($sformatf("last_p%0d", i), 64'(m_axis_tlast[i]), 64'(mon_e.last));
                    end
                end
            end
        end
    end

    task automatic drive(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l,
                         input logic [DESTW-1:0] dest, input bit first);
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
        s_axis_tdest  = dest;
        s_axis_tvalid = 1'b1;
        if (first) pkt_dest = int'(dest);
    endtask

    // Waits (bounded) for the beat on the inputs to be accepted and records it.
    task automatic complete_beat();
        int    n = 0;
        beat_t b;
        @(negedge clk);
        while (!s_axis_tready && n < 200) begin
            n++;
            @(negedge clk);
        end
        last_wait = n;
        check("accept_in_time", 64'(s_axis_tready), 64'd1);
        if (s_axis_tready && pkt_dest < M) begin
            b.data = s_axis_tdata;
            b.keep = s_axis_tkeep;
            b.last = s_axis_tlast;
            exp_q[pkt_dest].push_back(b);
            lat_q.push_back('{c: cyc, port: pkt_dest});
        end
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l,
                             input logic [DESTW-1:0] dest, input bit first);
        drive(d, k, l, dest, first);
        complete_beat();
    endtask

    task automatic drain();
        int n = 0;
        while (pending() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_done", 64'(pending()), 64'd0);
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_rst_counters();
        rst_counters = 1'b1;
        @(posedge clk);
        #1;
        rst_counters = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench timed out");
    end

    initial begin
        rst           = 1'b1;
        rst_counters  = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tdest  = '0;
        m_axis_tready = '1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        s_axis_tvalid = 1'b1;
        #1;
        check("rst_s_tready", 64'(s_axis_tready), 64'd0);
        check("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rst_m_tdata", m_axis_tdata[63:0], 64'd0);
        check("rst_m_tlast", 64'(m_axis_tlast), 64'd0);
        check("rst_pkt_count", 64'(pkt_count), 64'd0);
        check("rst_discard_count", 64'(discard_count), 64'd0);
        s_axis_tvalid = 1'b0;
        @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        check("idle_s_tready", 64'(s_axis_tready), 64'd1);

        // 3-beat packet to port 1, all ready
        send_beat(64'hA000_0000_0000_0001, 8'hFF, 1'b0, 2'd1, 1'b1);
        send_beat(64'hA000_0000_0000_0002, 8'hF0, 1'b0, 2'd1, 1'b0);
        send_beat(64'hA000_0000_0000_0003, 8'h03, 1'b1, 2'd1, 1'b0);
        drain();
        check("t1_pkt_count", 64'(pkt_count), 64'h010);

        // 4-beat packet to tdest=3 is dropped with ready held high
        for (int i = 0; i < 4; i++) begin
            send_beat(64'hB000_0000_0000_0000 + 64'(i), 8'hFF, i == 3, 2'd3, i == 0);
            check("t2_discard_no_wait", 64'(last_wait), 64'd0);
        end
        drain();
        check("t2_discard_count", 64'(discard_count), 64'd1);
        check("t2_pkt_count", 64'(pkt_count), 64'h010);
        send_beat(64'hB100_0000_0000_0000, 8'hFF, 1'b1, 2'd0, 1'b1);
        drain();
        check("t2_next_pkt_port0", 64'(pkt_count), 64'h011);

        // Port 2 stalled for 5 cycles mid-packet, tdest toggled mid-packet
        send_beat(64'hC000_0000_0000_0001, 8'hFF, 1'b0, 2'd2, 1'b1);
        send_beat(64'hC000_0000_0000_0002, 8'h7F, 1'b0, 2'd0, 1'b0);
        m_axis_tready[2] = 1'b0;
        drive(64'hC000_0000_0000_0003, 8'h3F, 1'b0, 2'd0, 1'b0);
        repeat (5) begin
            @(negedge clk);
            check("t3_stall_s_tready", 64'(s_axis_tready), 64'd0);
            check("t3_stall_m_tvalid", 64'(m_axis_tvalid), 64'b100);
            check("t3_stall_data", m_axis_tdata[2*DW +: DW], 64'hC000_0000_0000_0002);
            s_axis_tdest = ~s_axis_tdest;
        end
        @(posedge clk);
        #1;
        m_axis_tready[2] = 1'b1;
        complete_beat();
        send_beat(64'hC000_0000_0000_0004, 8'h01, 1'b1, 2'd1, 1'b0);
        drain();
        check("t3_pkt_count", 64'(pkt_count), 64'h111);

        // Back-to-back single-beat packets 0,1,2,0; includes a zero-tkeep beat
        pulse_rst_counters();
        check("t4_cleared_pkt", 64'(pkt_count), 64'd0);
        check("t4_cleared_discard", 64'(discard_count), 64'd0);
        send_beat(64'hD000_0000_0000_0000, 8'hFF, 1'b1, 2'd0, 1'b1);
        send_beat(64'hD000_0000_0000_0001, 8'h00, 1'b1, 2'd1, 1'b1);
        send_beat(64'hD000_0000_0000_0002, 8'h55, 1'b1, 2'd2, 1'b1);
        send_beat(64'hD000_0000_0000_0003, 8'hAA, 1'b1, 2'd0, 1'b1);
        drain();
        check("t4_pkt_count", 64'(pkt_count), 64'h112);

        // rst_counters coincides with a port-0 tlast handshake
        send_beat(64'hE000_0000_0000_0000, 8'hFF, 1'b1, 2'd0, 1'b1);
        pulse_rst_counters();
        drain();
        check("t5_clear_priority", 64'(pkt_count), 64'd0);

        // Saturation of packet and discard counters
        for (int i = 0; i < 17; i++) begin
            send_beat(64'hE100_0000_0000_0000 + 64'(i), 8'hFF, 1'b1, 2'd0, 1'b1);
        end
        for (int i = 0; i < 17; i++) begin
            send_beat(64'hE200_0000_0000_0000 + 64'(i), 8'hFF, 1'b1, 2'd3, 1'b1);
        end
        drain();
        check("t5_pkt_saturate", 64'(pkt_count), 64'h00F);
        check("t5_discard_saturate", 64'(discard_count), 64'hF);

`ifdef EGRESS_ROUTER_BYTE_COUNT_EN
        pulse_rst_counters();
        send_beat(64'hF000_0000_0000_0001, 8'hFF, 1'b0, 2'd0, 1'b1);
        send_beat(64'hF000_0000_0000_0002, 8'h0F, 1'b1, 2'd0, 1'b0);
        drain();
        check("byte_count_p0", 64'(byte_count[SW-1:0]), 64'd12);
        check("byte_count_others", 64'(byte_count[M*SW-1:SW]), 64'd0);
`endif

        // Reset in the middle of a packet to port 1 with a beat still pending
        send_beat(64'h1000_0000_0000_0001, 8'hFF, 1'b0, 2'd1, 1'b1);
        send_beat(64'h1000_0000_0000_0002, 8'hFF, 1'b0, 2'd1, 1'b0);
        m_axis_tready = '0;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_s_tready", 64'(s_axis_tready), 64'd0);
        @(posedge clk);
        #1;
        check("midrst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("midrst_pkt_count", 64'(pkt_count), 64'd0);
        check("midrst_discard", 64'(discard_count), 64'd0);
        for (int i = 0; i < M; i++) exp_q[i].delete();
        lat_q.delete();
        rst = 1'b0;
        m_axis_tready = '1;
        send_beat(64'h2000_0000_0000_0001, 8'hAA, 1'b1, 2'd2, 1'b1);
        drain();
        check("midrst_new_pkt_port2", 64'(pkt_count), 64'h100);

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
